uart_byte_receiver: RTL and testbench

- Serial front end of the terminal: the stage directly upstream of the VT100 parser.
- Converts the asynchronous UART line (8N1, LSB first) into the byte stream the parser consumes.
- Per byte, presents `data` with a one-cycle `dataReady` pulse.
- Flags framing errors and line breaks for debug and status display.

---
 rtl/uart_byte_receiver.sv | 177 +++++++++++++++++
 tb/tb_uart_byte_receiver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver feeding the VT100 parser: 16x oversampling, 2-of-3 majority
// per bit, one-cycle pulses for a good byte, a framing error and a line break.
module uart_byte_receiver #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       dataReady,
  output logic [7:0] data,
  output logic       frameError,
  output logic       breakDetected,
  output logic       busy
);

  // Rounded divide; the design assumes DIV >= 2 and OVERSAMPLE == 16.
  localparam int TICK_RATE = BAUD_RATE * OVERSAMPLE;
  localparam int DIV       = (CLK_FREQ + TICK_RATE / 2) / TICK_RATE;
  localparam int DIV_W     = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } stateE;

  stateE            state, stateNext;
  logic             rxMeta, rxs;
  logic [DIV_W-1:0] divCnt, divNext;
  logic [3:0]       sc, scNext;
  logic [2:0]       bitIdx, bitIdxNext;
  logic [7:0]       shiftReg, shiftNext;
  logic             sampleA, sampleANext;
  logic             sampleB, sampleBNext;
  logic [7:0]       dataNext;
  logic             readyNext, frameNext, breakNext;

  logic tick;
  logic isDecision;
  logic isBitEnd;
  logic majority;

  // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, so
      // rxMeta -> rxs really forms two stages instead of collapsing into one wire.
      rxMeta <= rxd;
      rxs    <= rxMeta;
    end
  end

  assign tick       = (state != IDLE) && (divCnt == DIV_LAST);
  // The ticks that bring sc to 7, 8 and 9 sample the line; the last one decides.
  assign isDecision = tick && (sc == 4'd8);
  assign isBitEnd   = tick && (sc == 4'd15);
  assign majority   = (sampleA & sampleB) | (sampleA & rxs) | (sampleB & rxs);

  always_comb begin
    // NOTE: every signal written here is given a default first; a path that leaves
    // one unassigned would otherwise infer a latch to hold its old value.
    stateNext   = state;
    divNext     = divCnt;
    scNext      = sc;
    bitIdxNext  = bitIdx;
    shiftNext   = shiftReg;
    sampleANext = sampleA;
    sampleBNext = sampleB;
    dataNext    = data;
    readyNext   = 1'b0;
    frameNext   = 1'b0;
    breakNext   = 1'b0;

    if (state != IDLE) begin
      divNext = tick ? '0 : divCnt + 1'b1;
    end

    if (tick) begin
      scNext = sc + 4'd1;
      if (sc == 4'd6) sampleANext = rxs;
      if (sc == 4'd7) sampleBNext = rxs;
    end

    unique case (state)
      IDLE: begin
        if (!rxs) stateNext = START;
      end

      START: begin
        if (isDecision && majority) begin
          stateNext = IDLE;
        end else if (isBitEnd) begin
          stateNext  = DATA;
          bitIdxNext = 3'd0;
        end
      end

      DATA: begin
        if (isDecision) shiftNext = {majority, shiftReg[7:1]};
        if (isBitEnd) begin
          if (bitIdx == 3'd7) stateNext = STOP;
          else                bitIdxNext = bitIdx + 3'd1;
        end
      end

      // A good stop bit releases the byte mid-bit so an early next start is not missed.
      STOP: begin
        if (isDecision) begin
          if (majority) begin
            stateNext = IDLE;
            dataNext  = shiftReg;
            readyNext = 1'b1;
          end else begin
            stateNext = WAIT_IDLE;
            frameNext = 1'b1;
            breakNext = (shiftReg == 8'h00);
            scNext    = 4'd0;
          end
        end
      end

      // sc counts consecutive high ticks here; any low tick restarts the count.
      WAIT_IDLE: begin
        if (tick) begin
          if (!rxs)              scNext    = 4'd0;
          else if (sc == 4'd15)  stateNext = IDLE;
        end
      end

      default: stateNext = IDLE;
    endcase

    if (stateNext == IDLE) begin
      divNext = '0;
      scNext  = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      divCnt        <= '0;
      sc            <= 4'd0;
      bitIdx        <= 3'd0;
      shiftReg      <= 8'h00;
      sampleA       <= 1'b1;
      sampleB       <= 1'b1;
      data          <= 8'h00;
      dataReady     <= 1'b0;
      frameError    <= 1'b0;
      breakDetected <= 1'b0;
    end else begin
      state         <= stateNext;
      divCnt        <= divNext;
      sc            <= scNext;
      bitIdx        <= bitIdxNext;
      shiftReg      <= shiftNext;
      sampleA       <= sampleANext;
      sampleB       <= sampleBNext;
      data          <= dataNext;
      dataReady     <= readyNext;
      frameError    <= frameNext;
      breakDetected <= breakNext;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at 7.3728 MHz / 115200 baud (DIV = 4, 64 clocks per bit).
module tb_uart_byte_receiver;

  localparam int BIT_CLKS = 64;
  localparam int PERIOD   = 10;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       dataReady;
  logic [7:0] data;
  logic       frameError;
  logic       breakDetected;
  logic       busy;

  int assertCount = 0;
  int failCount   = 0;

  int          drCount = 0;
  int          feCount = 0;
  int          bdCount = 0;
  logic [7:0]  drData[$];
  longint      drTime[$];

  uart_byte_receiver #(
    .CLK_FREQ  (7372800),
    .BAUD_RATE (115200),
    .OVERSAMPLE(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rxd          (rxd),
    .dataReady    (dataReady),
    .data         (data),
    .frameError   (frameError),
    .breakDetected(breakDetected),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
    assertCount++;
    assert (observed >= lo && observed <= hi)
    else begin
      failCount++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
    end
  endtask

  // Called on a falling clock edge; returns with the line back at idle.
  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = stopBit;
    repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Pulse log, sampled away from the active edge.
  always @(negedge clk) begin
    if (dataReady) begin
      drCount++;
      drData.push_back(data);
      drTime.push_back($time);
    end
    if (frameError)    feCount++;
    if (breakDetected) bdCount++;
    if (dataReady || frameError) check("ready_and_error_exclusive", {31'd0, dataReady & frameError}, 32'd0);
  end

  initial begin
    longint tFall;
    int     lat;
    int     waited;
    int     base;
    logic [7:0] burst [4];
    burst = '{8'h1B, 8'h5B, 8'h32, 8'h4A};

    rst = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dataReady", {31'd0, dataReady}, 32'd0);
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_frameError", {31'd0, frameError}, 32'd0);
    check("reset_breakDetected", {31'd0, breakDetected}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Single good byte and its latency from the line falling edge.
    tFall = $time;
    sendFrame(8'h1B, 1'b1);
    repeat (16) @(negedge clk);
    check("t1_ready_count", drCount, 1);
    check("t1_data", {24'd0, data}, 32'h1B);
    check("t1_no_frame_error", feCount, 0);
    lat = (drTime.size() > 0) ? int'((drTime[0] - tFall) / PERIOD) : 0;
    checkRange("t1_latency", lat, 608, 616);

    // 20-clock glitch must be rejected as a false start.
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    waited = 20;
    while (busy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("t2_busy_cleared", {31'd0, busy}, 32'd0);
    repeat (100) @(negedge clk);
    check("t2_no_ready", drCount, 1);
    check("t2_no_frame_error", feCount, 0);

    // Bad stop bit, then recovery with a good byte.
    sendFrame(8'h41, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("t3_frame_error", feCount, 1);
    check("t3_no_break", bdCount, 0);
    check("t3_no_ready", drCount, 1);
    check("t3_data_held", {24'd0, data}, 32'h1B);
    sendFrame(8'h42, 1'b1);
    repeat (16) @(negedge clk);
    check("t3_ready_count", drCount, 2);
    check("t3_data", {24'd0, data}, 32'h42);

    // Long break: one error/break pair, then a good byte.
    rxd = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    check("t4_no_ready_in_break", drCount, 2);
    rxd = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    sendFrame(8'h0A, 1'b1);
    repeat (16) @(negedge clk);
    check("t4_frame_error_once", feCount, 2);
    check("t4_break_once", bdCount, 1);
    check("t4_ready_count", drCount, 3);
    check("t4_data", {24'd0, data}, 32'h0A);

    // Back-to-back frames with no idle gap.
    base = drData.size();
    for (int i = 0; i < 4; i++) sendFrame(burst[i], 1'b1);
    repeat (16) @(negedge clk);
    check("t5_ready_count", drCount, 7);
    for (int i = 0; i < 4; i++) begin
      if (drData.size() > base + i) check($sformatf("t5_data_%0d", i), {24'd0, drData[base + i]}, {24'd0, burst[i]});
    end
    for (int i = 1; i < 4; i++) begin
      if (drTime.size() > base + i)
        checkRange($sformatf("t5_spacing_%0d", i), int'((drTime[base + i] - drTime[base + i - 1]) / PERIOD), 636, 644);
    end

    // Reset in the middle of 0x55 (during data bit 4); the line is released to idle.
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0] ? 1'b0 : 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_reset_dataReady", {31'd0, dataReady}, 32'd0);
    check("t6_reset_data", {24'd0, data}, 32'h00);
    check("t6_reset_frameError", {31'd0, frameError}, 32'd0);
    check("t6_reset_breakDetected", {31'd0, breakDetected}, 32'd0);
    check("t6_reset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10 * BIT_CLKS) @(negedge clk);
    check("t6_no_aborted_ready", drCount, 7);
    check("t6_no_aborted_error", feCount, 2);
    sendFrame(8'h33, 1'b1);
    repeat (16) @(negedge clk);
    check("t6_ready_count", drCount, 8);
    check("t6_data", {24'd0, data}, 32'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
